// File: rtl/uart_rx_if.sv
// Interface for the UART receiver: serial line and frame configuration in, received word and status out.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx_in;
  logic [5:0]            prescale;
  logic                  par_en;
  logic                  par_typ;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stop_err;

  modport master (
    output rx_in, prescale, par_en, par_typ,
    input  p_data, data_valid, par_err, stop_err
  );

  modport slave (
    input  rx_in, prescale, par_en, par_typ,
    output p_data, data_valid, par_err, stop_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, oversampled 3-sample majority voting, optional parity,
// registered word / valid pulse / error flags.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_rx_prev;
  logic [5:0]            r_p;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [5:0]            r_edge_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_s0;
  logic                  r_s1;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_bad;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stop_err;

  logic       w_rx_s;
  logic       w_start;
  logic [5:0] w_p_dec;
  logic [5:0] w_half;
  logic       w_wrap;
  logic       w_decide;
  logic       w_maj;

  assign w_rx_s   = r_sync2;
  // a start needs a real 1->0 edge, so a stuck-low line cannot retrigger
  assign w_start  = (r_state == IDLE) && !w_rx_s && r_rx_prev;
  assign w_p_dec  = (bus.prescale == 6'd16) ? 6'd16 :
                    (bus.prescale == 6'd32) ? 6'd32 : 6'd8;
  assign w_half   = {1'b0, r_p[5:1]};
  assign w_wrap   = (r_edge_cnt == (r_p - 6'd1));
  assign w_decide = (r_edge_cnt == w_half);
  assign w_maj    = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);

  // synchronizer and previous-value flop for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= bus.rx_in;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (w_start) w_next = START; else w_next = IDLE;
      START: begin
        if (w_decide && w_maj) w_next = IDLE;
        else if (w_wrap)       w_next = DATA;
        else                   w_next = START;
      end
      DATA: begin
        if (w_wrap && (r_bit_cnt == LAST_BIT)) w_next = r_par_en ? PARITY : STOP;
        else                                   w_next = DATA;
      end
      PARITY: if (w_wrap) w_next = STOP; else w_next = PARITY;
      // leave at mid-stop to give margin for back-to-back frames
      STOP:   if (w_decide) w_next = IDLE; else w_next = STOP;
      default: w_next = IDLE;
    endcase
  end

  // frame configuration, counters, sampling and shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p        <= 6'd8;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_edge_cnt <= 6'd0;
      r_bit_cnt  <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_shift    <= '0;
      r_par_bad  <= 1'b0;
    end else begin
      if (w_start) begin
        r_p       <= w_p_dec;
        r_par_en  <= bus.par_en;
        r_par_typ <= bus.par_typ;
      end
      // the detect cycle itself is edge 0 of the start bit
      if (r_state == IDLE)     r_edge_cnt <= w_start ? 6'd1 : 6'd0;
      else if (w_next == IDLE) r_edge_cnt <= 6'd0;
      else if (w_wrap)         r_edge_cnt <= 6'd0;
      else                     r_edge_cnt <= r_edge_cnt + 6'd1;
      if (r_state != DATA) r_bit_cnt <= '0;
      else if (w_wrap)     r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + {{(BW-1){1'b0}}, 1'b1};
      if (r_state != IDLE) begin
        if (r_edge_cnt == (w_half - 6'd2)) r_s0 <= w_rx_s;
        if (r_edge_cnt == (w_half - 6'd1)) r_s1 <= w_rx_s;
      end
      if ((r_state == DATA) && w_decide) r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
      if (w_start) r_par_bad <= 1'b0;
      else if ((r_state == PARITY) && w_decide) r_par_bad <= ((^r_shift) ^ r_par_typ) != w_maj;
    end
  end

  // registered outputs, updated the cycle after the stop decision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stop_err   <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      if (w_start) begin
        r_par_err  <= 1'b0;
        r_stop_err <= 1'b0;
      end
      if ((r_state == STOP) && w_decide) begin
        r_stop_err <= ~w_maj;
        r_par_err  <= r_par_bad;
        if (w_maj && !r_par_bad) begin
          r_p_data     <= r_shift;
          r_data_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.p_data     = r_p_data;
  assign bus.data_valid = r_data_valid;
  assign bus.par_err    = r_par_err;
  assign bus.stop_err   = r_stop_err;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, hand-written corner sequences,
// and randomized frames checked against a frame-level reference model.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_WIDTH(8)) u_if ();

  uart_rx #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         pq_cyc[$];
  logic [7:0] pq_data[$];
  int         tq[$];

  always @(negedge clk) begin
    if (u_if.data_valid === 1'b1) begin
      pq_cyc.push_back(cyc);
      pq_data.push_back(u_if.p_data);
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] m_pdata;
  logic       m_perr;
  logic       m_serr;

  typedef struct {
    logic [7:0] data;
    logic [5:0] ps;
    logic       pe;
    logic       pt;
    logic       pbit;
    logic       sbit;
    int         hold;
    logic [7:0] exp_pdata;
    int         exp_pulses;
    logic       exp_perr;
    logic       exp_serr;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int eff_p(input logic [5:0] ps);
    if (ps == 6'd16) return 16;
    if (ps == 6'd32) return 32;
    return 8;
  endfunction

  function automatic int lat(input int p, input logic pe);
    return 2 + p * (1 + 8 + int'(pe)) + p / 2 + 1;
  endfunction

  // frame-level model: parity judged by total count of ones, stop by its level
  task automatic model_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic pbit, input logic sbit, output logic ok);
    m_serr = ~sbit;
    m_perr = pe && ((($countones(d) + int'(pbit)) % 2) != int'(pt));
    ok = !m_serr && !m_perr;
    if (ok) m_pdata = d;
  endtask

  task automatic idle(input int n);
    u_if.rx_in = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // drive one frame; called and returns at posedge+1
  task automatic send(input logic [7:0] d, input logic [5:0] ps, input logic pe, input logic pt,
                      input logic pbit, input logic sbit, input int gbit, input int gcyc,
                      input int abort_bit, input bit junk);
    int p;
    int nb;
    logic bits[11];
    p = eff_p(ps);
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    nb = 9;
    if (pe) begin
      bits[nb] = pbit;
      nb++;
    end
    bits[nb] = sbit;
    nb++;
    u_if.prescale = ps;
    u_if.par_en   = pe;
    u_if.par_typ  = pt;
    tq.push_back(cyc);
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < p; j++) begin
        if (k == abort_bit && j == p / 2) return;
        if (junk && k == 1 && j == 0) begin
          u_if.prescale = 6'($urandom);
          u_if.par_en   = ~pe;
          u_if.par_typ  = ~pt;
        end
        u_if.rx_in = (k == gbit && j == gcyc) ? ~bits[k] : bits[k];
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic clear_q();
    pq_cyc.delete();
    pq_data.delete();
    tq.delete();
  endtask

  initial begin
    logic ok;
    logic [7:0] d;
    logic [5:0] ps;
    logic pe, pt, pbit, sbit;
    int p, gbit, gcyc, sel;
    logic [7:0] b2b_d[3];

    vt[0] = '{8'hA5, 6'd8,  1'b1, 1'b0, 1'b0, 1'b1, 0,   8'hA5, 1, 1'b0, 1'b0};
    vt[1] = '{8'h3C, 6'd16, 1'b1, 1'b1, 1'b0, 1'b1, 0,   8'hA5, 0, 1'b1, 1'b0};
    vt[2] = '{8'h81, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, 128, 8'hA5, 0, 1'b0, 1'b1};
    vt[3] = '{8'h12, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 0,   8'h12, 1, 1'b0, 1'b0};
    vt[4] = '{8'h5A, 6'd12, 1'b1, 1'b1, 1'b1, 1'b1, 0,   8'h5A, 1, 1'b0, 1'b0};

    u_if.rx_in = 1'b1;
    u_if.prescale = 6'd8;
    u_if.par_en = 1'b0;
    u_if.par_typ = 1'b0;
    m_pdata = 8'h00; m_perr = 1'b0; m_serr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_p_data", 32'(u_if.p_data), 32'h0);
    chk("reset_data_valid", 32'(u_if.data_valid), 32'h0);
    chk("reset_par_err", 32'(u_if.par_err), 32'h0);
    chk("reset_stop_err", 32'(u_if.stop_err), 32'h0);
    rst = 1'b1;
    idle(10);

    for (int i = 0; i < 5; i++) begin
      clear_q();
      send(vt[i].data, vt[i].ps, vt[i].pe, vt[i].pt, vt[i].pbit, vt[i].sbit, -1, 0, -1, 1'b0);
      model_frame(vt[i].data, vt[i].pe, vt[i].pt, vt[i].pbit, vt[i].sbit, ok);
      u_if.rx_in = vt[i].sbit;
      repeat (vt[i].hold) begin
        @(posedge clk); #1;
      end
      idle(2 * eff_p(vt[i].ps));
      chk($sformatf("vec%0d_pulses", i), 32'(pq_cyc.size()), 32'(vt[i].exp_pulses));
      chk($sformatf("vec%0d_p_data", i), 32'(u_if.p_data), 32'(vt[i].exp_pdata));
      chk($sformatf("vec%0d_par_err", i), 32'(u_if.par_err), 32'(vt[i].exp_perr));
      chk($sformatf("vec%0d_stop_err", i), 32'(u_if.stop_err), 32'(vt[i].exp_serr));
      if (vt[i].exp_pulses == 1 && pq_cyc.size() == 1)
        chk($sformatf("vec%0d_latency", i), 32'(pq_cyc[0] - tq[0]),
            32'(lat(eff_p(vt[i].ps), vt[i].pe)));
    end

    // start glitch: 3 low cycles at prescale 16, then a clean frame must still be received
    clear_q();
    u_if.prescale = 6'd16; u_if.par_en = 1'b0; u_if.par_typ = 1'b0;
    u_if.rx_in = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    idle(48);
    m_perr = 1'b0; m_serr = 1'b0;
    chk("glitch_pulses", 32'(pq_cyc.size()), 32'h0);
    chk("glitch_p_data", 32'(u_if.p_data), 32'h5A);
    chk("glitch_par_err", 32'(u_if.par_err), 32'h0);
    chk("glitch_stop_err", 32'(u_if.stop_err), 32'h0);
    clear_q();
    send(8'hC3, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, -1, 1'b0);
    model_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, ok);
    idle(4);
    chk("post_glitch_pulses", 32'(pq_cyc.size()), 32'h1);
    chk("post_glitch_p_data", 32'(u_if.p_data), 32'hC3);

    // noise rejection and back-to-back frames at prescale 8
    clear_q();
    b2b_d[0] = 8'h0F; b2b_d[1] = 8'h55; b2b_d[2] = 8'hAA;
    send(b2b_d[0], 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 3, 3, -1, 1'b0);
    send(b2b_d[1], 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, -1, 1'b0);
    send(b2b_d[2], 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, -1, 1'b0);
    for (int i = 0; i < 3; i++) model_frame(b2b_d[i], 1'b0, 1'b0, 1'b0, 1'b1, ok);
    idle(8);
    chk("b2b_pulses", 32'(pq_cyc.size()), 32'h3);
    if (pq_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("b2b%0d_data", i), 32'(pq_data[i]), 32'(b2b_d[i]));
        chk($sformatf("b2b%0d_latency", i), 32'(pq_cyc[i] - tq[i]), 32'(lat(8, 1'b0)));
      end
    end

    // reset during data bit 4
    clear_q();
    send(8'h77, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0, 5, 1'b0);
    rst = 1'b0;
    u_if.rx_in = 1'b1;
    #1;
    m_pdata = 8'h00; m_perr = 1'b0; m_serr = 1'b0;
    chk("midrst_p_data", 32'(u_if.p_data), 32'h0);
    chk("midrst_data_valid", 32'(u_if.data_valid), 32'h0);
    chk("midrst_par_err", 32'(u_if.par_err), 32'h0);
    chk("midrst_stop_err", 32'(u_if.stop_err), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(16);
    chk("midrst_no_pulse", 32'(pq_cyc.size()), 32'h0);
    clear_q();
    send(8'h12, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, -1, 1'b0);
    model_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, ok);
    idle(4);
    chk("after_rst_pulses", 32'(pq_cyc.size()), 32'h1);
    chk("after_rst_p_data", 32'(u_if.p_data), 32'h12);

    // randomized frames against the model
    for (int n = 0; n < 24; n++) begin
      clear_q();
      sel = $urandom_range(0, 3);
      ps = (sel == 0) ? 6'd8 : (sel == 1) ? 6'd16 : (sel == 2) ? 6'd32 : 6'($urandom);
      p = eff_p(ps);
      d = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      pbit = (^d) ^ pt;
      if ($urandom_range(0, 4) == 0) pbit = ~pbit;
      sbit = ($urandom_range(0, 5) != 0);
      gbit = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : -1;
      gcyc = $urandom_range(0, p - 1);
      send(d, ps, pe, pt, pbit, sbit, gbit, gcyc, -1, 1'b1);
      model_frame(d, pe, pt, pbit, sbit, ok);
      chk($sformatf("rnd%0d_pulses", n), 32'(pq_cyc.size()), ok ? 32'h1 : 32'h0);
      if (ok && pq_cyc.size() == 1)
        chk($sformatf("rnd%0d_latency", n), 32'(pq_cyc[0] - tq[0]), 32'(lat(p, pe)));
      chk($sformatf("rnd%0d_p_data", n), 32'(u_if.p_data), 32'(m_pdata));
      chk($sformatf("rnd%0d_par_err", n), 32'(u_if.par_err), 32'(m_perr));
      chk($sformatf("rnd%0d_stop_err", n), 32'(u_if.stop_err), 32'(m_serr));
      if (sbit) idle($urandom_range(0, 3));
      else      idle($urandom_range(1, 3));
    end

    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
